// File: rtl/wide_add_sequencer.sv
// Multi-cycle wide adder/subtractor: one WIDTH-bit lookahead adder is reused
// over WORDS slices, least significant first, with the carry held in a register.

module carryLookAheadAdder #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o,
  output logic             ovf_o
);

  logic [WIDTH-1:0] gen;
  logic [WIDTH-1:0] prop;
  logic [WIDTH:0]   carry;

  // Carries are resolved in 4-bit lookahead groups; each group sees the
  // carry entering its lowest bit.
  function automatic logic [WIDTH:0] lookahead(input logic [WIDTH-1:0] g,
                                               input logic [WIDTH-1:0] p,
                                               input logic             ci);
    logic [WIDTH:0] cv;
    logic           term;
    logic           run;
    cv    = '0;
    cv[0] = ci;
    for (int i = 0; i < WIDTH; i++) begin
      term = g[i];
      run  = p[i];
      for (int m = i - 1; m >= (i / 4) * 4; m--) begin
        term = term | (run & g[m]);
        run  = run & p[m];
      end
      cv[i+1] = term | (run & cv[(i / 4) * 4]);
    end
    return cv;
  endfunction

  assign gen    = a_i & b_i;
  assign prop   = a_i ^ b_i;
  assign carry  = lookahead(gen, prop, cin_i);
  assign sum_o  = prop ^ carry[WIDTH-1:0];
  assign cout_o = carry[WIDTH];
  assign ovf_o  = carry[WIDTH] ^ carry[WIDTH-1];

endmodule

module wide_add_sequencer #(
  parameter int WIDTH = 32,
  parameter int WORDS = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   sub,
  input  logic [WIDTH*WORDS-1:0] a,
  input  logic [WIDTH*WORDS-1:0] b,
  output logic                   busy,
  output logic                   done,
  output logic [WIDTH*WORDS-1:0] sum,
  output logic                   cout,
  output logic                   overflow
);

  localparam int N  = WIDTH * WORDS;
  localparam int KW = $clog2(WORDS);
  localparam logic [KW-1:0] K_LAST = KW'(WORDS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state_q, state_d;
  logic [KW-1:0]  k_q, k_d;
  logic [N-1:0]   a_q, a_d;
  logic [N-1:0]   b_q, b_d;
  logic           carry_q, carry_d;
  logic [N-1:0]   sum_q, sum_d;
  logic           cout_q, cout_d;
  logic           ovf_q, ovf_d;

  logic [31:0]      base;
  logic [WIDTH-1:0] add_sum;
  logic             add_cout;
  logic             add_ovf;

  assign base = 32'(k_q) * 32'(WIDTH);

  // b_q already holds the inverted operand for subtraction.
  carryLookAheadAdder #(.WIDTH(WIDTH)) u_cla (
    .a_i    (a_q[base +: WIDTH]),
    .b_i    (b_q[base +: WIDTH]),
    .cin_i  (carry_q),
    .sum_o  (add_sum),
    .cout_o (add_cout),
    .ovf_o  (add_ovf)
  );

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub;
          k_d     = '0;
          sum_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[base +: WIDTH] = add_sum;
        carry_d              = add_cout;
        k_d                  = k_q + KW'(1);
        if (k_q == K_LAST) begin
          cout_d  = add_cout;
          ovf_d   = add_ovf;
          k_d     = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign sum      = sum_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Bench for wide_add_sequencer (WIDTH=32, WORDS=4): directed corner cases and
// random operations scored against a plain-arithmetic model.

module tb_wide_add_sequencer;

  localparam int N = 128;
  // Capture edge, then one edge per slice: done is seen after the 4th edge
  // following the capture edge (the 5th edge counting the capture edge).
  localparam int EXP_LAT = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         sub;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         busy;
  logic         done;
  logic [N-1:0] sum;
  logic         cout;
  logic         overflow;

  int tests_run = 0;
  int fails     = 0;

  wide_add_sequencer #(.WIDTH(32), .WORDS(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .sub      (sub),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .cout     (cout),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [N-1:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic void model(input logic [N-1:0] ma, input logic [N-1:0] mb, input logic ms,
                                output logic [N-1:0] es, output logic ec, output logic eo);
    logic [N:0] u;
    logic [N:0] r;
    if (ms) begin
      es = ma - mb;
      ec = (ma >= mb);
      r  = {ma[N-1], ma} - {mb[N-1], mb};
    end else begin
      u  = {1'b0, ma} + {1'b0, mb};
      es = u[N-1:0];
      ec = u[N];
      r  = {ma[N-1], ma} + {mb[N-1], mb};
    end
    eo = r[N] ^ r[N-1];
  endfunction

  task automatic run_op(input logic [N-1:0] oa, input logic [N-1:0] ob, input logic os,
                        input bit hold, output logic [N-1:0] r_sum, output logic r_cout,
                        output logic r_ovf, output int lat, output int pulses,
                        output logic busy_after);
    @(negedge clk);
    a = oa; b = ob; sub = os; start = 1'b1;
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    a = rand128(); b = rand128(); sub = 1'($urandom_range(0, 1));
    lat = -1; pulses = 0;
    for (int n = 1; n <= 10; n++) begin
      @(posedge clk); #1;
      if (done) begin
        pulses++;
        if (lat < 0) lat = n;
        start = 1'b0;
      end
    end
    start = 1'b0;
    r_sum = sum; r_cout = cout; r_ovf = overflow; busy_after = busy;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    tests_run++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", busy); end
    tests_run++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got=%b exp=0", done); end
    tests_run++; if (sum !== '0) begin fails++; $display("FAIL reset_sum got=%h exp=0", sum); end
    tests_run++; if (cout !== 1'b0) begin fails++; $display("FAIL reset_cout got=%b exp=0", cout); end
    tests_run++; if (overflow !== 1'b0) begin fails++; $display("FAIL reset_ovf got=%b exp=0", overflow); end
    rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [N-1:0] ta [5];
    logic [N-1:0] tb [5];
    logic         ts [5];
    logic [N-1:0] xs [5];
    logic         xc [5];
    logic         xo [5];
    logic [N-1:0] gs;
    logic         gc, go, gb;
    int           lat, pulses;
    ta[0] = {1'b0, {(N-1){1'b1}}}; tb[0] = 1; ts[0] = 0; xs[0] = {1'b1, {(N-1){1'b0}}}; xc[0] = 0; xo[0] = 1;
    ta[1] = '1;                    tb[1] = 1; ts[1] = 0; xs[1] = '0;                    xc[1] = 1; xo[1] = 0;
    ta[2] = 128'hFFFF_FFFF;        tb[2] = 1; ts[2] = 0; xs[2] = 128'h1_0000_0000;      xc[2] = 0; xo[2] = 0;
    ta[3] = '0;                    tb[3] = 1; ts[3] = 1; xs[3] = '1;                    xc[3] = 0; xo[3] = 0;
    ta[4] = {1'b1, {(N-1){1'b0}}}; tb[4] = 1; ts[4] = 1; xs[4] = {1'b0, {(N-1){1'b1}}}; xc[4] = 1; xo[4] = 1;
    for (int i = 0; i < 5; i++) begin
      run_op(ta[i], tb[i], ts[i], 1'b0, gs, gc, go, lat, pulses, gb);
      tests_run++; if (gs !== xs[i]) begin fails++; $display("FAIL dir%0d_sum got=%h exp=%h", i, gs, xs[i]); end
      tests_run++; if (gc !== xc[i]) begin fails++; $display("FAIL dir%0d_cout got=%b exp=%b", i, gc, xc[i]); end
      tests_run++; if (go !== xo[i]) begin fails++; $display("FAIL dir%0d_ovf got=%b exp=%b", i, go, xo[i]); end
      tests_run++; if (lat !== EXP_LAT) begin fails++; $display("FAIL dir%0d_latency got=%0d exp=%0d", i, lat, EXP_LAT); end
      tests_run++; if (pulses !== 1) begin fails++; $display("FAIL dir%0d_pulses got=%0d exp=1", i, pulses); end
      tests_run++; if (gb !== 1'b0) begin fails++; $display("FAIL dir%0d_busy_after got=%b exp=0", i, gb); end
    end
  endtask

  task automatic test_random();
    logic [N-1:0] ra, rb, gs, es;
    logic         rs, gc, go, gb, ec, eo;
    int           lat, pulses;
    for (int i = 0; i < 30; i++) begin
      ra = rand128(); rb = rand128(); rs = 1'($urandom_range(0, 1));
      if (i % 3 == 0) begin ra[N-1 -: 2] = 2'b01; rb[N-1 -: 2] = rs ? 2'b11 : 2'b01; end
      if (i % 5 == 0) rb = ra;
      model(ra, rb, rs, es, ec, eo);
      run_op(ra, rb, rs, 1'b0, gs, gc, go, lat, pulses, gb);
      tests_run++; if (gs !== es) begin fails++; $display("FAIL rnd%0d_sum got=%h exp=%h", i, gs, es); end
      tests_run++; if (gc !== ec) begin fails++; $display("FAIL rnd%0d_cout got=%b exp=%b", i, gc, ec); end
      tests_run++; if (go !== eo) begin fails++; $display("FAIL rnd%0d_ovf got=%b exp=%b", i, go, eo); end
      tests_run++; if (pulses !== 1) begin fails++; $display("FAIL rnd%0d_pulses got=%0d exp=1", i, pulses); end
    end
  endtask

  task automatic test_start_held();
    logic [N-1:0] ra, rb, gs, es;
    logic         gc, go, gb, ec, eo;
    int           lat, pulses;
    ra = rand128(); rb = rand128();
    model(ra, rb, 1'b1, es, ec, eo);
    run_op(ra, rb, 1'b1, 1'b1, gs, gc, go, lat, pulses, gb);
    tests_run++; if (pulses !== 1) begin fails++; $display("FAIL held_pulses got=%0d exp=1", pulses); end
    tests_run++; if (lat !== EXP_LAT) begin fails++; $display("FAIL held_latency got=%0d exp=%0d", lat, EXP_LAT); end
    tests_run++; if (gs !== es) begin fails++; $display("FAIL held_sum got=%h exp=%h", gs, es); end
    tests_run++; if (gc !== ec) begin fails++; $display("FAIL held_cout got=%b exp=%b", gc, ec); end
    tests_run++; if (gb !== 1'b0) begin fails++; $display("FAIL held_busy_after got=%b exp=0", gb); end
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] a1, b1, a2, b2, es;
    logic         ec, eo;
    bit           seen;
    a1 = rand128(); b1 = rand128(); a2 = rand128(); b2 = rand128();
    @(negedge clk);
    a = a1; b = b1; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = rand128(); b = rand128();
    seen = 0;
    for (int n = 0; n < 10 && !seen; n++) begin @(posedge clk); #1; seen = done; end
    tests_run++; if (!seen) begin fails++; $display("FAIL b2b_first_done got=0 exp=1"); end
    model(a1, b1, 1'b0, es, ec, eo);
    tests_run++; if (sum !== es) begin fails++; $display("FAIL b2b_first_sum got=%h exp=%h", sum, es); end
    // start raised during the DONE cycle must be ignored.
    start = 1'b1; a = rand128(); b = rand128();
    @(posedge clk); #1;
    tests_run++; if (busy !== 1'b0) begin fails++; $display("FAIL b2b_done_start_ignored busy=%b exp=0", busy); end
    a = a2; b = b2; sub = 1'b1;
    @(posedge clk); #1;
    tests_run++; if (busy !== 1'b1) begin fails++; $display("FAIL b2b_idle_start_accepted busy=%b exp=1", busy); end
    start = 1'b0; a = rand128(); b = rand128(); sub = 1'b0;
    seen = 0;
    for (int n = 0; n < 10 && !seen; n++) begin @(posedge clk); #1; seen = done; end
    tests_run++; if (!seen) begin fails++; $display("FAIL b2b_second_done got=0 exp=1"); end
    @(posedge clk); #1;
    model(a2, b2, 1'b1, es, ec, eo);
    tests_run++; if (sum !== es) begin fails++; $display("FAIL b2b_second_sum got=%h exp=%h", sum, es); end
    tests_run++; if (overflow !== eo) begin fails++; $display("FAIL b2b_second_ovf got=%b exp=%b", overflow, eo); end
  endtask

  task automatic test_reset_priority();
    @(negedge clk);
    rst = 1'b1; start = 1'b1; a = rand128(); b = rand128();
    @(posedge clk); #1;
    tests_run++; if (busy !== 1'b0) begin fails++; $display("FAIL rstprio_busy got=%b exp=0", busy); end
    rst = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    tests_run++; if (busy !== 1'b0) begin fails++; $display("FAIL rstprio_busy_later got=%b exp=0", busy); end
    tests_run++; if (sum !== '0) begin fails++; $display("FAIL rstprio_sum got=%h exp=0", sum); end
  endtask

  task automatic test_reset_abort();
    logic [N-1:0] gs, es, ra, rb;
    logic         gc, go, gb, ec, eo;
    int           lat, pulses;
    // Leave cout/overflow set so the abort visibly clears them.
    run_op({1'b1, {(N-1){1'b0}}}, 1, 1'b1, 1'b0, gs, gc, go, lat, pulses, gb);
    @(negedge clk);
    a = 128'h1234_5678; b = 128'h1111_1111; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    tests_run++; if (busy !== 1'b0) begin fails++; $display("FAIL abort_busy got=%b exp=0", busy); end
    tests_run++; if (sum !== '0) begin fails++; $display("FAIL abort_sum got=%h exp=0", sum); end
    tests_run++; if (cout !== 1'b0) begin fails++; $display("FAIL abort_cout got=%b exp=0", cout); end
    tests_run++; if (overflow !== 1'b0) begin fails++; $display("FAIL abort_ovf got=%b exp=0", overflow); end
    pulses = 0;
    for (int n = 0; n < 8; n++) begin @(posedge clk); #1; if (done) pulses++; end
    tests_run++; if (pulses !== 0) begin fails++; $display("FAIL abort_no_done got=%0d exp=0", pulses); end
    ra = rand128(); rb = rand128();
    model(ra, rb, 1'b0, es, ec, eo);
    run_op(ra, rb, 1'b0, 1'b0, gs, gc, go, lat, pulses, gb);
    tests_run++; if (gs !== es) begin fails++; $display("FAIL abort_next_sum got=%h exp=%h", gs, es); end
    tests_run++; if (lat !== EXP_LAT) begin fails++; $display("FAIL abort_next_latency got=%0d exp=%0d", lat, EXP_LAT); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_start_held();
    test_back_to_back();
    test_reset_priority();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
